// File: rtl/lcd_pkg.sv
// Shared constants and arbiter FSM encoding for the LCD data path.
package lcd_pkg;

    localparam int unsigned NSLOT  = 6;
    localparam int unsigned SLOT_W = 3;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PENDING  = 2'b01,
        COOLDOWN = 2'b10
    } arb_state_e;

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin grant across NREQ requesters; the pointer advances past each granted requester.
module lcd_rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int unsigned      gidx;
    int unsigned      best;

    // Pick the valid requester with the smallest distance from the pointer.
    always_comb begin
        found   = 1'b0;
        gidx    = 0;
        best    = NREQ;
        grant_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_valid_i[i] && (((i + NREQ - 32'(ptr_q)) % NREQ) < best)) begin
                best  = (i + NREQ - 32'(ptr_q)) % NREQ;
                gidx  = i;
                found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_o[i] = found && (gidx == i);
        end
        ptr_d = found ? PTR_W'((gidx + 1) % NREQ) : ptr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/lcd_data_arbiter.sv
// Arbitrates slot writes into a shadow bank and commits dirty slots at a bounded rate.
// Define LCD_ARB_DROPCNT_EN to build the illegal-slot drop counter.
module lcd_data_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 5000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_slot,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 freeze,
    output logic [DATA_W-1:0]    data0,
    output logic [DATA_W-1:0]    data1,
    output logic [DATA_W-1:0]    data2,
    output logic [DATA_W-1:0]    data3,
    output logic [DATA_W-1:0]    data4,
    output logic [DATA_W-1:0]    data5,
    output logic                 commit_pulse,
    output logic [7:0]           drop_cnt
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);

    logic [NREQ-1:0]   gnt;
    logic              transfer;
    logic [SLOT_W-1:0] wr_slot;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] shadow_q [NSLOT];
    logic [DATA_W-1:0] shadow_d [NSLOT];
    logic [DATA_W-1:0] data_q   [NSLOT];
    logic [DATA_W-1:0] data_d   [NSLOT];
    logic [NSLOT-1:0]  dirty_q, dirty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pulse_q, pulse_d;
    arb_state_e        state_q, state_d;
    logic              hold_expired;
    logic              commit;

    lcd_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .grant_o     (gnt)
    );

    assign req_ready = gnt;
    assign transfer  = |gnt;

    always_comb begin
        wr_slot = '0;
        wr_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wr_slot = req_slot[SLOT_W*i +: SLOT_W];
                wr_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    assign hold_expired = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    // Commit is gated only by hold/freeze/dirty so it can fire straight from IDLE
    // or COOLDOWN, giving one-edge latency and exact HOLD_CYCLES spacing.
    always_comb begin
        shadow_d = shadow_q;
        data_d   = data_q;
        dirty_d  = dirty_q;
        hold_d   = hold_q;
        state_d  = state_q;
        commit   = hold_expired && !freeze && (dirty_q != '0);
        pulse_d  = commit;

        if (commit) begin
            for (int unsigned s = 0; s < NSLOT; s++) begin
                if (dirty_q[s]) data_d[s] = shadow_q[s];
            end
            dirty_d = '0;
            hold_d  = '0;
        end else if (!hold_expired) begin
            hold_d = hold_q + HOLD_W'(1);
        end

        // A write on the commit edge re-sets dirty after the clear above.
        for (int unsigned s = 0; s < NSLOT; s++) begin
            if (transfer && (wr_slot == SLOT_W'(s))) begin
                shadow_d[s] = wr_data;
                dirty_d[s]  = 1'b1;
            end
        end

        case (state_q)
            IDLE, PENDING: begin
                if (commit)                state_d = COOLDOWN;
                else if (dirty_q != '0)    state_d = PENDING;
                else                       state_d = IDLE;
            end
            COOLDOWN: begin
                if (commit)                state_d = COOLDOWN;
                else if (hold_expired)     state_d = (dirty_q != '0) ? PENDING : IDLE;
            end
            default:                       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_q <= '{default: '0};
            data_q   <= '{default: '0};
            dirty_q  <= '0;
            hold_q   <= HOLD_W'(HOLD_CYCLES - 1);
            pulse_q  <= 1'b0;
            state_q  <= IDLE;
        end else begin
            shadow_q <= shadow_d;
            data_q   <= data_d;
            dirty_q  <= dirty_d;
            hold_q   <= hold_d;
            pulse_q  <= pulse_d;
            state_q  <= state_d;
        end
    end

    assign data0        = data_q[0];
    assign data1        = data_q[1];
    assign data2        = data_q[2];
    assign data3        = data_q[3];
    assign data4        = data_q[4];
    assign data5        = data_q[5];
    assign commit_pulse = pulse_q;

`ifdef LCD_ARB_DROPCNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_q <= '0;
        end else if (transfer && (wr_slot >= SLOT_W'(NSLOT)) && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_data_arbiter.sv
// Directed bench for lcd_data_arbiter with NREQ = 4, HOLD_CYCLES = 8.
module tb_lcd_data_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [11:0] req_slot;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic        freeze;
    logic [15:0] data0, data1, data2, data3, data4, data5;
    logic        commit_pulse;
    logic [7:0]  drop_cnt;

    int passed = 0;
    int total  = 0;

    lcd_data_arbiter #(.NREQ(4), .HOLD_CYCLES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_slot     (req_slot),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .freeze       (freeze),
        .data0        (data0),
        .data1        (data1),
        .data2        (data2),
        .data3        (data3),
        .data4        (data4),
        .data5        (data5),
        .commit_pulse (commit_pulse),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input int r, input logic [2:0] slot, input logic [15:0] val);
        req_valid        = '0;
        req_valid[r]     = 1'b1;
        req_slot[3*r +: 3]   = slot;
        req_data[16*r +: 16] = val;
    endtask

    logic [15:0] exp_drop;

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_slot  = '0;
        req_data  = '0;
        freeze    = 1'b0;
`ifdef LCD_ARB_DROPCNT_EN
        exp_drop = 16'd2;
`else
        exp_drop = 16'd0;
`endif
        tick(); tick();
        chk("rst_data0", data0, 0);
        chk("rst_data5", data5, 0);
        chk("rst_pulse", commit_pulse, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_drop", drop_cnt, 0);
        reset = 1'b1;
        tick();

        // Single write, immediate commit.
        drive(0, 3'd2, 16'h1234);
        #1 chk("t1_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        chk("t1_data2_pre", data2, 0);
        chk("t1_pulse_pre", commit_pulse, 0);
        tick();
        chk("t1_data2", data2, 16'h1234);
        chk("t1_pulse", commit_pulse, 1);
        chk("t1_data0", data0, 0);
        chk("t1_data5", data5, 0);
        tick();
        chk("t1_pulse_off", commit_pulse, 0);

        // Reset to start arbitration from pointer 0.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // All requesters valid continuously.
        req_valid = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            req_slot[3*r +: 3]   = 3'(r);
            req_data[16*r +: 16] = 16'hA000 + 16'(r);
        end
        for (int k = 0; k < 5; k++) begin
            #1 chk("t2_grant", req_ready, 4'b0001 << (k % 4));
            tick();
        end
        req_valid = '0;
        chk("t2_data0", data0, 16'hA000);
        for (int k = 0; k < 10; k++) tick();
        chk("t2_data1", data1, 16'hA001);
        chk("t2_data2", data2, 16'hA002);
        chk("t2_data3", data3, 16'hA003);
        for (int k = 0; k < 8; k++) tick();

        // Rate-limited second commit.
        drive(0, 3'd0, 16'h0001);
        tick();
        req_valid = '0;
        tick();
        chk("t3_first", data0, 16'h0001);
        chk("t3_pulse1", commit_pulse, 1);
        drive(0, 3'd0, 16'h0002);
        tick();
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t3_hold_data", data0, 16'h0001);
            chk("t3_hold_pulse", commit_pulse, 0);
        end
        tick();
        chk("t3_second", data0, 16'h0002);
        chk("t3_pulse2", commit_pulse, 1);

        // Freeze holds the outputs.
        freeze = 1'b1;
        drive(1, 3'd5, 16'hBEEF);
        tick();
        drive(1, 3'd5, 16'hCAFE);
        tick();
        req_valid = '0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t4_frozen", data5, 0);
            chk("t4_nopulse", commit_pulse, 0);
        end
        freeze = 1'b0;
        tick();
        chk("t4_data5", data5, 16'hCAFE);
        chk("t4_pulse", commit_pulse, 1);
        tick();
        chk("t4_pulse_off", commit_pulse, 0);
        for (int k = 0; k < 10; k++) tick();

        // Illegal slot writes are accepted and discarded.
        drive(2, 3'd7, 16'hFFFF);
        #1 chk("t5_ready", req_ready, 4'b0100);
        tick();
        #1 chk("t5_ready2", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_nopulse", commit_pulse, 0);
        end
        chk("t5_data0", data0, 16'h0002);
        chk("t5_data1", data1, 16'hA001);
        chk("t5_data5", data5, 16'hCAFE);
        chk("t5_drop", drop_cnt, 32'(exp_drop));

        // Write during cooldown, then reset mid-count.
        drive(0, 3'd1, 16'h5555);
        tick();
        req_valid = '0;
        tick();
        chk("t6_data1", data1, 16'h5555);
        drive(0, 3'd1, 16'h7777);
        tick();
        req_valid = '0;
        tick(); tick();
        #2 reset = 1'b0;
        #1 chk("t6_rst_data1", data1, 0);
        chk("t6_rst_data0", data0, 0);
        chk("t6_rst_data5", data5, 0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("t6_nocommit", commit_pulse, 0);
        end
        chk("t6_data1_lost", data1, 0);
        drive(3, 3'd4, 16'h4444);
        tick();
        req_valid = '0;
        tick();
        chk("t6_data4", data4, 16'h4444);
        chk("t6_data1_still0", data1, 0);
        chk("t6_pulse", commit_pulse, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
